hart_lsu: RTL and testbench
===========================

# hart_lsu

Load/store unit that sits between the hart's execute stage and a realistic, variable-latency data memory, replacing the combinational dmem port. It accepts one byte, half-word or word access per transaction and aligns the address. It generates byte masks and lane-shifted write data, and sign/zero-extends read data. It waits on a ready/valid memory handshake with a configurable timeout, and flags misaligned and timed-out accesses back to the pipeline.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before a fault is reported. A value of 0 disables the timeout.
- `RESET_READY`, default 1: value of `o_req_ready` after reset is released.
- `i_clk`  in  1  global clock.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_req_valid`  in  1  pipeline presents an access.
- `o_req_ready`  out  1  LSU is idle and can accept an access.
- `i_req_wen`  in  1  1 = store, 0 = load.
- `i_req_size`  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
- `i_req_unsigned`  in  1  zero-extend the load result (lbu/lhu).
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-justified.
- `o_rsp_valid`  out  1  one-cycle completion pulse.
- `o_rsp_rdata`  out  32  extended load result; 0 for stores, traps and faults.
- `o_rsp_trap`  out  1  misaligned or illegal-size access; no memory access was made.
- `o_rsp_fault`  out  1  memory timeout.
- `o_mem_addr`  out  32  word-aligned address (bits [1:0] = 0).
- `o_mem_ren`  out  1  read request.
- `o_mem_wen`  out  1  write request. Never asserted together with `o_mem_ren`.
- `o_mem_wdata`  out  32  lane-shifted store data.
- `o_mem_mask`  out  4  byte-lane enables.
- `i_mem_ready`  in  1  memory accepts the request this cycle.
- `i_mem_valid`  in  1  read data, or write acknowledge, is valid.
- `i_mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, WAIT, RESP. With `HART_LSU_SPLIT_EN` defined, REQ2 and WAIT2 are added.
- IDLE:
  - `o_req_ready = 1`.
  - On `i_req_valid & o_req_ready`, all request fields are captured and `off = addr[1:0]` is latched.
  - An illegal size, or a misaligned access that is not handled by the split logic, goes to RESP with trap=1.
  - Any other access goes to REQ.
- REQ:
  - Drive `o_mem_addr = {addr[31:2],2'b00}`.
  - Drive `o_mem_mask = base_mask << off`, where base_mask is 0001, 0011 or 1111 for byte, half and word.
  - Drive `o_mem_wdata = wdata << (8*off)`.
  - Drive `ren`/`wen` according to `i_req_wen`.
  - Hold all of the above until `i_mem_ready`, then go to WAIT.
- WAIT:
  - Memory outputs are deasserted.
  - `i_mem_valid` is ignored in all other states.
  - On `i_mem_valid`: load `i_mem_rdata`, then go to RESP (or to REQ2 for a split access).
  - The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT` without `i_mem_valid`, go to RESP with fault=1.
- RESP:
  - `o_rsp_valid = 1` for exactly one cycle, then IDLE.
  - Load result is `(rdata >> 8*off)` truncated to the access size, then sign-extended, or zero-extended when `i_req_unsigned` is set.
- Misaligned means: half at an odd address, or word with `off != 0`.

## Timing
- Reset (asynchronous, `i_rst_n = 0`):
  - State is IDLE and every output is 0, including `o_req_ready`.
  - The timeout counter is cleared.
  - An in-flight access is abandoned: memory requests drop immediately and no response is produced.
- On release, `o_req_ready` takes `RESET_READY` from the first clock edge.
- Best-case latency is 3 cycles: accept at cycle 0, REQ with `i_mem_ready` at cycle 1, `i_mem_valid` at cycle 2, `o_rsp_valid` at cycle 3.
- A trap responds at cycle 1 with no memory traffic.
- A fault responds `TIMEOUT + 1` cycles after entering WAIT.
- `o_req_ready` is 0 in every state except IDLE, so no new access is accepted during RESP.
- `i_mem_valid` in the same cycle as `i_mem_ready` is not observed. The memory must return it at least one cycle later.

## Configuration
- `HART_LSU_SPLIT_EN` undefined: every misaligned access traps.
- `HART_LSU_SPLIT_EN` defined, misaligned accesses that stay within one word (half at offset 1) complete in a single beat.
- `HART_LSU_SPLIT_EN` defined, accesses crossing a word boundary (half at offset 3, word at offset 1–3) use two beats:
  - Beat 1 (REQ/WAIT): address `A & ~3`, mask `base_mask << off` truncated to 4 bits.
  - Beat 2 (REQ2/WAIT2): address `(A & ~3) + 4`, wrapping modulo 2^32, mask carries the remaining low lanes, store data is `wdata >> 8*(4-off)`.
  - Load result is `{beat2, beat1} >> 8*off`, then extended as above.
  - A timeout on either beat produces fault=1. If beat 1 was a store it has already been written.

## Test plan
- Byte load at `0x1003`, memory returns `0x80AABBCC`: `o_mem_mask = 1000`, `o_mem_addr = 0x1000`; with `i_req_unsigned = 0`, `o_rsp_rdata = 0xFFFFFF80`; with `i_req_unsigned = 1`, `o_rsp_rdata = 0x00000080`.
- Half store of `0x1234` at `0x2002`: `o_mem_wdata = 0x12340000`, `o_mem_mask = 1100`, `wen = 1` held across 3 cycles of `i_mem_ready = 0`.
- Word load at `0x3001`:
  - Without the macro: `o_rsp_trap = 1` at cycle 1 and no `ren`.
  - With the macro, memory returns `0x44332211` at `0x3000` and `0x88776655` at `0x3004`: two beats with masks `1110` then `0001`, `o_rsp_rdata = 0x55443322`.
- `TIMEOUT = 4`, `i_mem_valid` held low: `o_rsp_fault = 1` and `o_rsp_rdata = 0` on the 5th cycle after entering WAIT.
- Assert `i_rst_n = 0` while in WAIT: all outputs go to 0 immediately; after release, the next access completes normally with no stale response.
- Size 3 request: trap at cycle 1; `o_req_ready` returns to 1 at cycle 2.

Source files
------------

// File: rtl/hart_lsu.sv
// hart_lsu: load/store unit between the execute stage and a ready/valid data
// memory. Handles byte/half/word accesses, lane masks, store-data shifting,
// load extension, misalignment traps and a WAIT-state timeout.
//
// Optional feature macro: HART_LSU_SPLIT_EN
//   undefined : every misaligned access traps
//   defined   : misaligned accesses are performed (word-crossing ones in two beats)
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_*  / o_req_ready         pipeline request handshake and payload
//   o_rsp_*                        one-cycle completion pulse, data, trap, fault
//   o_mem_*                        word-aligned memory request (addr, ren/wen, data, mask)
//   i_mem_ready/valid/rdata        memory accept, completion and read data
module hart_lsu #(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          RESET_READY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_trap,
  output logic        o_rsp_fault,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
`ifdef HART_LSU_SPLIT_EN
  localparam int unsigned LANE_W = 8;
`else
  localparam int unsigned LANE_W = 4;
`endif
  localparam int unsigned DATA_W = 8 * LANE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
`ifdef HART_LSU_SPLIT_EN
    , ST_REQ2
    , ST_WAIT2
`endif
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               armed;

  logic               wen_q, wen_n;
  logic [1:0]         size_q, size_n;
  logic               uns_q, uns_n;
  logic [31:0]        addr_q, addr_n;
  logic [31:0]        wdata_q, wdata_n;
`ifdef HART_LSU_SPLIT_EN
  logic [31:0]        lo_q, lo_n;
  logic               cross_q;
`endif

  logic               req_bad;
  logic               timed_out;
  logic [LANE_W-1:0]  lane_mask;
  logic [DATA_W-1:0]  lane_wdata;

  logic               ready_n, rsp_valid_n, trap_n, fault_n;
  logic [31:0]        rdata_n;
  logic [31:0]        mem_addr_n, mem_wdata_n;
  logic [3:0]         mem_mask_n;
  logic               mem_ren_n, mem_wen_n;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Shift the selected bytes down to lane 0, then truncate and extend.
  function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (size)
      2'd0:    return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Requests that must trap without touching memory.
`ifdef HART_LSU_SPLIT_EN
  assign req_bad = (i_req_size == 2'd3);
  assign cross_q = ((size_q == 2'd1) && (addr_q[1:0] == 2'd3)) ||
                   ((size_q == 2'd2) && (addr_q[1:0] != 2'd0));
`else
  assign req_bad = (i_req_size == 2'd3) ||
                   ((i_req_size == 2'd1) && i_req_addr[0]) ||
                   ((i_req_size == 2'd2) && (i_req_addr[1:0] != 2'd0));
`endif

  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  // Next state, captured request, and next values of every registered output.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wen_n   = wen_q;
    size_n  = size_q;
    uns_n   = uns_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
`ifdef HART_LSU_SPLIT_EN
    lo_n    = lo_q;
`endif
    trap_n  = 1'b0;
    fault_n = 1'b0;
    rdata_n = '0;

    unique case (state)
      ST_IDLE: begin
        if (i_req_valid && o_req_ready) begin
          wen_n   = i_req_wen;
          size_n  = i_req_size;
          uns_n   = i_req_unsigned;
          addr_n  = i_req_addr;
          wdata_n = i_req_wdata;
          if (req_bad) begin
            state_n = ST_RESP;
            trap_n  = 1'b1;
          end else begin
            state_n = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_ready) begin
          state_n = ST_WAIT;
          cnt_n   = '0;
        end
      end
      ST_WAIT: begin
        if (i_mem_valid) begin
          state_n = ST_RESP;
          rdata_n = wen_q ? 32'h0 : load_ext({32'h0, i_mem_rdata}, addr_q[1:0], size_q, uns_q);
`ifdef HART_LSU_SPLIT_EN
          if (cross_q) begin
            state_n = ST_REQ2;
            rdata_n = '0;
            lo_n    = i_mem_rdata;
          end
`endif
        end else if (timed_out) begin
          state_n = ST_RESP;
          fault_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef HART_LSU_SPLIT_EN
      ST_REQ2: begin
        if (i_mem_ready) begin
          state_n = ST_WAIT2;
          cnt_n   = '0;
        end
      end
      ST_WAIT2: begin
        if (i_mem_valid) begin
          state_n = ST_RESP;
          rdata_n = wen_q ? 32'h0 : load_ext({i_mem_rdata, lo_q}, addr_q[1:0], size_q, uns_q);
        end else if (timed_out) begin
          state_n = ST_RESP;
          fault_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    // Lanes for the (possibly two-beat) access; the upper half feeds beat 2.
    lane_mask  = LANE_W'(base_mask(size_n)) << addr_n[1:0];
    lane_wdata = DATA_W'(wdata_n) << {addr_n[1:0], 3'b000};

    mem_addr_n  = '0;
    mem_wdata_n = '0;
    mem_mask_n  = '0;
    mem_ren_n   = 1'b0;
    mem_wen_n   = 1'b0;
    if (state_n == ST_REQ) begin
      mem_addr_n  = {addr_n[31:2], 2'b00};
      mem_wdata_n = lane_wdata[31:0];
      mem_mask_n  = lane_mask[3:0];
      mem_ren_n   = !wen_n;
      mem_wen_n   = wen_n;
    end
`ifdef HART_LSU_SPLIT_EN
    if (state_n == ST_REQ2) begin
      mem_addr_n  = {addr_n[31:2], 2'b00} + 32'd4;
      mem_wdata_n = lane_wdata[63:32];
      mem_mask_n  = lane_mask[7:4];
      mem_ren_n   = !wen_n;
      mem_wen_n   = wen_n;
    end
`endif

    ready_n     = (state_n == ST_IDLE) && (armed || RESET_READY);
    rsp_valid_n = (state_n == ST_RESP);
  end

  // Request capture, timeout counter and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt         <= '0;
      armed       <= 1'b0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
`ifdef HART_LSU_SPLIT_EN
      lo_q        <= '0;
`endif
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_trap  <= 1'b0;
      o_rsp_fault <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_ren   <= 1'b0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= '0;
      o_mem_mask  <= '0;
    end else begin
      cnt         <= cnt_n;
      armed       <= 1'b1;
      wen_q       <= wen_n;
      size_q      <= size_n;
      uns_q       <= uns_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
`ifdef HART_LSU_SPLIT_EN
      lo_q        <= lo_n;
`endif
      o_req_ready <= ready_n;
      o_rsp_valid <= rsp_valid_n;
      o_rsp_rdata <= rdata_n;
      o_rsp_trap  <= trap_n;
      o_rsp_fault <= fault_n;
      o_mem_addr  <= mem_addr_n;
      o_mem_ren   <= mem_ren_n;
      o_mem_wen   <= mem_wen_n;
      o_mem_wdata <= mem_wdata_n;
      o_mem_mask  <= mem_mask_n;
    end
  end

endmodule

// File: tb/tb_hart_lsu.sv
// tb_hart_lsu: directed, table-driven bench for hart_lsu (TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hart_lsu;

  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_trap, rsp_fault;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ren, mem_wen, mem_ready, mem_valid;
  logic [3:0]  mem_mask;

  int n_cmp = 0;
  int n_bad = 0;

  hart_lsu #(.TIMEOUT(TO), .RESET_READY(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_size(req_size), .i_req_unsigned(req_unsigned), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_trap(rsp_trap),
    .o_rsp_fault(rsp_fault),
    .o_mem_addr(mem_addr), .o_mem_ren(mem_ren), .o_mem_wen(mem_wen),
    .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wen;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          rdy_dly;
    int          vld_dly;
    bit          early;
    bit          trap;
    logic [31:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit wen, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
  endtask

  // One full transaction with a cycle-exact memory responder.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'(1));
    drive_req(v.wen, v.size, v.uns, v.addr, v.wdata);
    @(negedge clk);
    req_valid = 1'b0;
    if (v.trap) begin
      chk("trap_flags", 64'({rsp_valid, rsp_trap, rsp_fault, mem_ren, mem_wen}), 64'(5'b11000));
      chk("trap_rdata", 64'(rsp_rdata), 64'(0));
      @(negedge clk);
      chk("trap_ready_back", 64'({req_ready, rsp_valid}), 64'(2'b10));
      return;
    end
    for (int i = 0; i <= v.rdy_dly; i++) begin
      chk("req_addr", 64'(mem_addr), 64'(v.e_addr));
      chk("req_mask", 64'(mem_mask), 64'(v.e_mask));
      chk("req_wdata", 64'(mem_wdata), 64'(v.e_wdata));
      chk("req_ren_wen", 64'({mem_ren, mem_wen, req_ready}), 64'({~v.wen, v.wen, 1'b0}));
      mem_ready = (i == v.rdy_dly);
      mem_valid = v.early;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    for (int i = 0; i <= v.vld_dly; i++) begin
      chk("wait_quiet", 64'({mem_ren, mem_wen, rsp_valid}), 64'(0));
      mem_valid = (i == v.vld_dly);
      mem_rdata = mem_valid ? v.mrdata : 32'h0BAD_0BAD;
      @(negedge clk);
    end
    mem_valid = 1'b0;
    chk("rsp_flags", 64'({rsp_valid, rsp_trap, rsp_fault}), 64'(3'b100));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.e_rdata));
    @(negedge clk);
    chk("rsp_pulse", 64'({rsp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    // wen size uns addr wdata mrdata rdy vld early trap | e_addr e_mask e_wdata e_rdata
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b0, 1'b0,
                     32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, 1'b0, 1'b0,
                     32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_1234, 32'h5555_5555, 3, 0, 1'b0, 1'b0,
                     32'h0000_2000, 4'b1100, 32'h1234_0000, 32'h0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, 1'b0,
                     32'h0000_4000, 4'b1111, 32'h0, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0, 0, 1'b0, 1'b0,
                     32'h0000_4000, 4'b1100, 32'h0, 32'hFFFF_8001});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 0, 4, 1'b0, 1'b0,
                     32'h0000_4000, 4'b1100, 32'h0, 32'h0000_8001});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_4001, 32'h0, 32'h0000_7F00, 1, 2, 1'b1, 1'b0,
                     32'h0000_4000, 4'b0010, 32'h0, 32'h0000_007F});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_5001, 32'h0000_00A5, 32'h0, 0, 0, 1'b0, 1'b0,
                     32'h0000_5000, 4'b0010, 32'h0000_A500, 32'h0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_6000, 32'hCAFE_BABE, 32'h1111_1111, 0, 1, 1'b0, 1'b0,
                     32'h0000_6000, 4'b1111, 32'hCAFE_BABE, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hBEEF_0000, 0, 0, 1'b0, 1'b0,
                     32'hFFFF_FFFC, 4'b1100, 32'h0, 32'hFFFF_BEEF});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_00FE, 0, 0, 1'b0, 1'b0,
                     32'h0000_1000, 4'b0001, 32'h0, 32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0});
`ifdef HART_LSU_SPLIT_EN
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 32'h00BE_EF00, 0, 0, 1'b0, 1'b0,
                     32'h0000_1000, 4'b0110, 32'h0, 32'hFFFF_BEEF});
`else
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_5003, 32'h0000_ABCD, 32'h0, 0, 0, 1'b0, 1'b1,
                     32'h0, 4'b0000, 32'h0, 32'h0});
`endif

    req_valid = 1'b0; req_wen = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;

    // Reset state.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_flags", 64'({req_ready, rsp_valid, rsp_trap, rsp_fault, mem_ren, mem_wen, mem_mask}), 64'(0));
    chk("reset_buses", {mem_addr, mem_wdata | rsp_rdata}, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 64'(req_ready), 64'(0));
    @(negedge clk);
    chk("ready_after_edge", 64'(req_ready), 64'(1));

    foreach (vecs[k]) run_vec(vecs[k]);

    // Timeout: fault on the (TO+1)th cycle after entering WAIT.
    @(negedge clk);
    drive_req(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("to_req_ren", 64'(mem_ren), 64'(1));
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i <= int'(TO); i++) begin
      chk("to_wait_no_rsp", 64'(rsp_valid), 64'(0));
      @(negedge clk);
    end
    chk("to_fault_flags", 64'({rsp_valid, rsp_trap, rsp_fault}), 64'(3'b101));
    chk("to_fault_rdata", 64'(rsp_rdata), 64'(0));
    @(negedge clk);
    chk("to_back_idle", 64'({rsp_valid, req_ready}), 64'(2'b01));

    // Reset while REQ (p=0) and while WAIT (p=1): abandon, no stale response.
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      drive_req(1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      if (p == 1) begin
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end
      chk("pre_rst_ren", 64'(mem_ren), 64'(p == 0));
      rst_n = 1'b0;
      #1;
      chk("rst_flags", 64'({req_ready, rsp_valid, rsp_trap, rsp_fault, mem_ren, mem_wen, mem_mask}), 64'(0));
      chk("rst_addr", 64'(mem_addr), 64'(0));
      mem_valid = 1'b1;
      mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("post_rst_no_rsp", 64'({rsp_valid, req_ready}), 64'(2'b01));
      end
      run_vec(vecs[3]);
    end

`ifdef HART_LSU_SPLIT_EN
    // Word load at 0x3001 split across 0x3000 and 0x3004.
    @(negedge clk);
    drive_req(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("split_b1_addr", 64'(mem_addr), 64'(32'h3000));
    chk("split_b1_mask", 64'({mem_mask, mem_ren}), 64'(5'b11101));
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h4433_2211;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("split_b2_addr", 64'(mem_addr), 64'(32'h3004));
    chk("split_b2_mask", 64'({mem_mask, mem_ren, rsp_valid}), 64'(6'b000110));
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h8877_6655;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("split_rsp", 64'({rsp_valid, rsp_trap, rsp_fault}), 64'(3'b100));
    chk("split_rdata", 64'(rsp_rdata), 64'(32'h5544_3322));
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
